hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the ID-stage hazard unit. It tracks pending register writes with a per-register latency-countdown scoreboard, so producers of arbitrary latency (ALU, load, multi-cycle mul/div) are covered, not only a single load in EX. It drives the pipeline hold, decides the branch/jump flush once operands are safe, and counts stall cycles. It sits beside the ID stage and is fed by decode and the ID/EX issue point.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero and never busy
AW, $clog2(NREG), register index width
MAX_LAT, 8, largest producer latency in cycles, from issue until the result can be forwarded
CW, $clog2(MAX_LAT+1), countdown width
PERF_W, 32, stall-counter width

Ports:
clk  in  1  clock
rst  in  1  reset
issue_valid  in  1  ID instruction advances to EX this cycle; effective only when hold=0
issue_wr  in  1  issuing instruction writes a register
issue_rd  in  AW  destination register
issue_lat  in  CW  producer latency: 1 = ALU, 2 = load, up to MAX_LAT
src1_ID  in  AW  first source register in ID
src2_ID  in  AW  second source register in ID
src1_used  in  1  src1_ID is actually read
src2_used  in  1  src2_ID is actually read
branch  in  1  conditional branch in ID
branch_taken  in  1  ID comparator result
jump  in  2  jump type; any nonzero value is a jump
flush_pipe  in  1  exception/external flush
hold  out  1  stall PC and IF/ID; insert bubble into ID/EX
branch_flush  out  1  flush IF/ID, redirect PC
busy_mask  out  NREG  bit r = pending write to register r
stall_cycles  out  PERF_W  saturating count of cycles with hold=1

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset behaviour:
  - All counters cnt[r] clear to 0 and stall_cycles clears to 0.
  - This makes hold=0, branch_flush=0 and busy_mask=0 in the cycle after rst.
  - rst asserted mid-operation discards every pending entry.
- Output timing: hold, branch_flush and busy_mask are combinational from cnt and the inputs. Counter updates take 1 cycle.
- Counter update, per register, in priority order:
  1. flush_pipe: all cnt clear to 0 next cycle; a same-cycle issue is ignored.
  2. Accepted issue (issue_valid & issue_wr & !hold & issue_rd!=0 & issue_lat!=0): cnt[issue_rd] <= min(issue_lat, MAX_LAT). Issue wins over a same-cycle decrement.
  3. Otherwise, if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  4. cnt[0] stays 0 always.
- issue_lat=0: no entry is created.
- Data hazard (RAW): stall when srcN_used & srcN!=0 & cnt[srcN]>1. When cnt==1 the value is forwardable into EX next cycle, so there is no stall.
- Branch/jump-register hazard: operands are compared in ID, so a branch stalls on any pending source.
  - If branch & srcN_used & cnt[srcN]!=0, stall.
- Write-after-write: stall if issue_valid & issue_wr & issue_rd!=0 & cnt[issue_rd] > issue_lat. This prevents an older long-latency write completing after a younger one.
- hold = OR of the RAW, branch and WAW stall terms.
- branch_flush = !hold & ((branch & branch_taken) | (jump!=0)).
  - It is suppressed while held, because the comparison is not yet valid.
  - It is forced to 0 while flush_pipe=1.
- stall_cycles increments on every cycle with hold=1 and rst=0, and saturates at all-ones.
- Source and destination both at zero: no hazard ever; register 0 is excluded everywhere.
- Simultaneous issue and RAW on the same register in one cycle: the RAW check uses the current cnt, not the value being written.

Decomposition:
- Package hazard_pkg holds:
  - NREG, AW, MAX_LAT and CW defaults;
  - latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4, LAT_DIV=8;
  - jump encoding constants.
- Sub-module sb_cell: one countdown counter with load, decrement and clear, plus busy and gt1 outputs. It is generated for registers 1..NREG-1.
- The top level holds the compare/OR trees, the branch logic and the perf counter.

Test Plan:
- Issue ALU to r5 (lat 1), next cycle src1=r5 used -> hold=0; busy_mask[5]=1 for exactly 1 cycle.
- Issue load to r3 (lat 2), next cycle src2=r3 used -> hold=1 for 1 cycle, then 0; stall_cycles=1.
- Issue mul to r7 (lat 4), then a branch on r7 with branch_taken=1:
  - hold stays 1 until cnt[7]=0, 4 cycles total;
  - branch_flush=1 only in the first cycle with hold=0.
- Issue div to r9 (lat 8), then an ALU write to r9 (lat 1) -> WAW hold until cnt[9]<=1. After that the second issue is accepted and cnt[9]=1.
- With r4 pending (cnt=3), assert flush_pipe together with an issue to r6 -> next cycle busy_mask=0, r6 not busy, hold=0.
- Assert rst with r2 pending at cnt=5 -> next cycle busy_mask=0 and stall_cycles=0. Also preload stall_cycles near all-ones and hold for 3 cycles -> the counter saturates at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared defaults and constants for the hazard scoreboard slice:
//   * default register-file geometry and producer latency range
//   * producer latency constants used by decode when filling issue_lat
//   * jump-type encoding carried on the jump bus
//   * clamp_lat(): limits a requested latency to the scoreboard's range
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int NREG_DEF    = 32;
    localparam int AW_DEF      = $clog2(NREG_DEF);
    localparam int MAX_LAT_DEF = 8;
    localparam int CW_DEF      = $clog2(MAX_LAT_DEF + 1);
    localparam int PERF_W_DEF  = 32;

    // Producer latencies, counted from issue until the result is forwardable.
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = 8;

    // Any nonzero jump type redirects the PC.
    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JAL  = 2'b01,
        JMP_JALR = 2'b10,
        JMP_RSVD = 2'b11
    } jump_e;

    // Latencies above the scoreboard range are tracked as the maximum.
    function automatic int clamp_lat(input int lat, input int max_lat);
        if (lat > max_lat) begin
            return max_lat;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
// Decode / issue side bundle of the hazard scoreboard.
//   master (pipeline): issue_valid/issue_wr/issue_rd/issue_lat, src1/src2 and
//                      their used flags, branch/branch_taken/jump, flush_pipe
//   slave  (scoreboard): returns hold, branch_flush and busy_mask
// ---------------------------------------------------------------------------
interface hazard_if #(
    parameter int NREG = hazard_pkg::NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = hazard_pkg::CW_DEF
) ();

    logic            issue_valid;
    logic            issue_wr;
    logic [AW-1:0]   issue_rd;
    logic [CW-1:0]   issue_lat;
    logic [AW-1:0]   src1_ID;
    logic [AW-1:0]   src2_ID;
    logic            src1_used;
    logic            src2_used;
    logic            branch;
    logic            branch_taken;
    logic [1:0]      jump;
    logic            flush_pipe;
    logic            hold;
    logic            branch_flush;
    logic [NREG-1:0] busy_mask;

    modport master (
        output issue_valid, issue_wr, issue_rd, issue_lat,
        output src1_ID, src2_ID, src1_used, src2_used,
        output branch, branch_taken, jump, flush_pipe,
        input  hold, branch_flush, busy_mask
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd, issue_lat,
        input  src1_ID, src2_ID, src1_used, src2_used,
        input  branch, branch_taken, jump, flush_pipe,
        output hold, branch_flush, busy_mask
    );

endinterface

// File: rtl/hazard_scoreboard_sb_cell.sv
// ---------------------------------------------------------------------------
// sb_cell
// One scoreboard entry: a latency countdown for a single register.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : discard the pending write (highest priority)
//   load       : start a new countdown at load_val (beats decrement)
//   load_val   : producer latency, already clamped to MAX_LAT
//   cnt_o      : current countdown value
//   busy_o     : a write is still pending (cnt != 0)
//   gt1_o      : result not yet forwardable next cycle (cnt > 1)
// ---------------------------------------------------------------------------
module sb_cell #(
    parameter int MAX_LAT = hazard_pkg::MAX_LAT_DEF,
    parameter int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt_o,
    output logic          busy_o,
    output logic          gt1_o
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next countdown value: clear, then load, then decrement toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != CNT_ZERO);
    assign gt1_o  = (cnt_q > CNT_ONE);

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage hazard unit built on a per-register latency-countdown scoreboard.
//   clk, rst     : clock, synchronous active-high reset
//   sb (slave)   : issue/decode inputs; hold, branch_flush, busy_mask outputs
//   stall_cycles : saturating count of cycles spent with hold asserted
// hold, branch_flush and busy_mask are combinational from the countdowns and
// the current decode inputs; countdowns update one cycle later.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG    = hazard_pkg::NREG_DEF,
    parameter int AW      = $clog2(NREG),
    parameter int MAX_LAT = hazard_pkg::MAX_LAT_DEF,
    parameter int CW      = $clog2(MAX_LAT + 1),
    parameter int PERF_W  = hazard_pkg::PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    hazard_if.slave           sb,
    output logic [PERF_W-1:0] stall_cycles
);
    import hazard_pkg::*;

    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
    localparam logic [AW-1:0]     REG_ZERO  = {AW{1'b0}};
    localparam logic [PERF_W-1:0] PERF_ONE  = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};

    logic [CW-1:0]   cnt_s [NREG];
    logic [NREG-1:0] busy_s;
    logic [NREG-1:0] gt1_s;
    logic [CW-1:0]   lat_clamp_s;
    logic            accept_s;
    logic            raw_s;
    logic            br_s;
    logic            waw_s;
    logic            hold_s;
    logic            is_jump_s;
    logic            flush_s;
    logic [PERF_W-1:0] stall_d;
    logic [PERF_W-1:0] stall_q;

    // Register 0 never holds a pending write.
    assign cnt_s[0]  = CNT_ZERO;
    assign busy_s[0] = 1'b0;
    assign gt1_s[0]  = 1'b0;

    assign lat_clamp_s = CW'(clamp_lat(int'(sb.issue_lat), MAX_LAT));

    // Issue is taken only when the pipeline actually advances; a zero latency
    // or a write to r0 leaves nothing to track.
    assign accept_s = sb.issue_valid & sb.issue_wr & ~hold_s
                    & (sb.issue_rd != REG_ZERO) & (sb.issue_lat != CNT_ZERO);

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        sb_cell #(
            .MAX_LAT (MAX_LAT),
            .CW      (CW)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .clr      (sb.flush_pipe),
            .load     (accept_s && (sb.issue_rd == AW'(r))),
            .load_val (lat_clamp_s),
            .cnt_o    (cnt_s[r]),
            .busy_o   (busy_s[r]),
            .gt1_o    (gt1_s[r])
        );
    end

    // Stall terms, all evaluated against the current countdowns so that a
    // same-cycle issue never hides or creates a RAW hazard.
    always_comb begin
        raw_s = 1'b0;
        br_s  = 1'b0;
        waw_s = 1'b0;
        // cnt == 1 is forwardable into EX next cycle, so only cnt > 1 stalls.
        if ((sb.src1_used && gt1_s[sb.src1_ID]) || (sb.src2_used && gt1_s[sb.src2_ID])) begin
            raw_s = 1'b1;
        end else begin
            raw_s = 1'b0;
        end
        // Branch operands are compared in ID, so any pending source stalls.
        if (sb.branch && ((sb.src1_used && busy_s[sb.src1_ID]) ||
                          (sb.src2_used && busy_s[sb.src2_ID]))) begin
            br_s = 1'b1;
        end else begin
            br_s = 1'b0;
        end
        // A younger write must not complete before an older, slower one.
        if (sb.issue_valid && sb.issue_wr && (sb.issue_rd != REG_ZERO) &&
            (cnt_s[sb.issue_rd] > sb.issue_lat)) begin
            waw_s = 1'b1;
        end else begin
            waw_s = 1'b0;
        end
    end

    assign hold_s    = raw_s | br_s | waw_s;
    assign is_jump_s = (jump_e'(sb.jump) != JMP_NONE);
    assign flush_s   = ~hold_s & ~sb.flush_pipe
                     & ((sb.branch & sb.branch_taken) | is_jump_s);

    // Saturating stall counter next value.
    always_comb begin
        stall_d = stall_q;
        if (hold_s && (stall_q != PERF_MAX)) begin
            stall_d = stall_q + PERF_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= PERF_ZERO;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign sb.hold         = hold_s;
    assign sb.branch_flush = flush_s;
    assign sb.busy_mask    = busy_s;
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed vector table for the documented scenarios, then randomized traffic
// against a per-register latency model, then a stall-counter saturation run.
// The counter width is narrowed so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int MAX_LAT = 8;
    localparam int CW      = 4;
    localparam int PERF_W  = 6;
    localparam int PMAX    = (1 << PERF_W) - 1;

    logic clk;
    logic rst;
    logic [PERF_W-1:0] stall_cycles;

    hazard_if #(.NREG(NREG), .AW(AW), .CW(CW)) bus ();

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .CW(CW), .PERF_W(PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sb           (bus),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv, iw;
        int          rd, lat, s1, s2;
        logic        u1, u2, br, bt;
        int          jmp;
        logic        fp;
        logic        e_hold, e_flush;
        logic [31:0] e_busy;
        int          e_stall;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining cycles per register and the stall count.
    int mcnt [NREG];
    int mstall;

    function automatic vec_t mk(input logic r, iv, iw, input int rd, lat, s1, s2,
                                input logic u1, u2, br, bt, input int jmp,
                                input logic fp, eh, ef, input logic [31:0] eb,
                                input int es);
        vec_t v;
        v.rst = r; v.iv = iv; v.iw = iw; v.rd = rd; v.lat = lat; v.s1 = s1; v.s2 = s2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.bt = bt; v.jmp = jmp; v.fp = fp;
        v.e_hold = eh; v.e_flush = ef; v.e_busy = eb; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected combinational outputs from the model state and the inputs.
    task automatic model_eval(input vec_t v, output logic h, output logic f,
                              output logic [31:0] bm);
        bit raw, brh, waw;
        raw = (v.u1 && v.s1 != 0 && mcnt[v.s1] > 1) || (v.u2 && v.s2 != 0 && mcnt[v.s2] > 1);
        brh = v.br && ((v.u1 && v.s1 != 0 && mcnt[v.s1] != 0) ||
                       (v.u2 && v.s2 != 0 && mcnt[v.s2] != 0));
        waw = v.iv && v.iw && v.rd != 0 && mcnt[v.rd] > v.lat;
        h = raw || brh || waw;
        f = !h && !v.fp && ((v.br && v.bt) || v.jmp != 0);
        bm = '0;
        for (int r = 1; r < NREG; r++) bm[r] = (mcnt[r] != 0);
    endtask

    task automatic model_step(input vec_t v, input logic h);
        bit acc;
        if (v.rst) begin
            for (int r = 0; r < NREG; r++) mcnt[r] = 0;
            mstall = 0;
        end else begin
            if (h && mstall < PMAX) mstall++;
            acc = v.iv && v.iw && !h && v.rd != 0 && v.lat != 0;
            for (int r = 1; r < NREG; r++) begin
                if (v.fp) mcnt[r] = 0;
                else if (acc && r == v.rd) mcnt[r] = (v.lat > MAX_LAT) ? MAX_LAT : v.lat;
                else if (mcnt[r] > 0) mcnt[r]--;
            end
        end
    endtask

    // Applies one cycle of inputs, compares outputs, then advances the clock.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag,
                             output logic hold_seen);
        logic h, f;
        logic [31:0] bm;
        rst              = v.rst;
        bus.issue_valid  = v.iv;
        bus.issue_wr     = v.iw;
        bus.issue_rd     = AW'(v.rd);
        bus.issue_lat    = CW'(v.lat);
        bus.src1_ID      = AW'(v.s1);
        bus.src2_ID      = AW'(v.s2);
        bus.src1_used    = v.u1;
        bus.src2_used    = v.u2;
        bus.branch       = v.br;
        bus.branch_taken = v.bt;
        bus.jump         = 2'(v.jmp);
        bus.flush_pipe   = v.fp;
        #2;
        model_eval(v, h, f, bm);
        if (use_tbl) begin
            chk({tag, " hold"},  64'(bus.hold),         64'(v.e_hold));
            chk({tag, " flush"}, 64'(bus.branch_flush), 64'(v.e_flush));
            chk({tag, " busy"},  64'(bus.busy_mask),    64'(v.e_busy));
            chk({tag, " stall"}, 64'(stall_cycles),     64'(v.e_stall));
        end else begin
            chk({tag, " hold"},  64'(bus.hold),         64'(h));
            chk({tag, " flush"}, 64'(bus.branch_flush), 64'(f));
            chk({tag, " busy"},  64'(bus.busy_mask),    64'(bm));
            chk({tag, " stall"}, 64'(stall_cycles),     64'(mstall));
        end
        hold_seen = bus.hold;
        @(posedge clk);
        model_step(v, h);
        #1;
    endtask

    vec_t tbl [$];
    vec_t idle;

    initial begin
        vec_t v;
        logic hs;
        bit done;

        idle = mk(0,0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,32'h0,0);
        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.issue_rd = '0; bus.issue_lat = '0;
        bus.src1_ID = '0; bus.src2_ID = '0; bus.src1_used = 1'b0; bus.src2_used = 1'b0;
        bus.branch = 1'b0; bus.branch_taken = 1'b0; bus.jump = 2'b00; bus.flush_pipe = 1'b0;
        for (int r = 0; r < NREG; r++) mcnt[r] = 0;
        mstall = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("reset hold",  64'(bus.hold),         64'd0);
        chk("reset flush", 64'(bus.branch_flush), 64'd0);
        chk("reset busy",  64'(bus.busy_mask),    64'd0);
        chk("reset stall", 64'(stall_cycles),     64'd0);
        @(posedge clk); #1;

        //            rst iv iw rd lat s1 s2  u1 u2 br bt jmp fp  hold flush busy     stall
        // ALU to r5, consumer next cycle: forwardable, busy for one cycle
        tbl.push_back(mk(0, 1, 1, 5, LAT_ALU, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 0,  0, 0, 32'h20,   0));
        tbl.push_back(idle);
        // load to r3, consumer next cycle: one stall
        tbl.push_back(mk(0, 1, 1, 3, LAT_LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0,  1, 0, 32'h8,    0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0,  0, 0, 32'h8,    1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    1));
        // mul to r7, taken branch on r7: held 4 cycles, flush on release
        tbl.push_back(mk(0, 1, 1, 7, LAT_MUL, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 1, 0, 0, 1, 0, 32'h80, 1 + i));
        tbl.push_back(mk(0, 0, 0, 0, 0, 7, 0,  1, 0, 1, 1, 0, 0,  0, 1, 32'h0,    5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    5));
        // div to r9 then ALU to r9: WAW hold until cnt <= 1, then accepted
        tbl.push_back(mk(0, 1, 1, 9, LAT_DIV, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    5));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 1, 1, 9, LAT_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 5 + i));
        tbl.push_back(mk(0, 1, 1, 9, LAT_ALU, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200, 12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h200, 12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    12));
        // r4 pending at 3, flush_pipe with a same-cycle issue to r6
        tbl.push_back(mk(0, 1, 1, 4, 3, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    12));
        tbl.push_back(mk(0, 1, 1, 6, 2, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 32'h10,   12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 6, 0,  1, 0, 1, 0, 0, 0,  0, 0, 32'h0,    12));
        // jump flush: suppressed by flush_pipe; not-taken branch has no flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1,  0, 0, 32'h0,    12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0,  0, 1, 32'h0,    12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 0, 32'h0,    12));
        // r0 is never tracked; latency 0 creates no entry
        tbl.push_back(mk(0, 1, 1, 0, 4, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0,  0, 1, 32'h0,    12));
        tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0,  1, 0, 1, 0, 0, 0,  0, 0, 32'h0,    12));
        // r2 pending at 5, reset discards it and clears the stall counter
        tbl.push_back(mk(0, 1, 1, 2, 5, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    12));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0,  1, 0, 0, 0, 0, 0,  1, 0, 32'h4,    12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0,  1, 0, 0, 0, 0, 0,  0, 0, 32'h0,    0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i), hs);
        end

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            v = idle;
            v.rst = ($urandom_range(0, 199) == 0);
            v.iv  = $urandom_range(0, 1);
            v.iw  = ($urandom_range(0, 3) != 0);
            v.rd  = $urandom_range(0, 7);
            v.lat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            v.s1  = $urandom_range(0, 7);
            v.s2  = $urandom_range(0, 7);
            v.u1  = $urandom_range(0, 1);
            v.u2  = $urandom_range(0, 1);
            v.br  = ($urandom_range(0, 3) == 0);
            v.bt  = $urandom_range(0, 1);
            v.jmp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            v.fp  = ($urandom_range(0, 49) == 0);
            run_cycle(v, 1'b0, "rand", hs);
        end

        // Saturation: reset, then repeated divide-consumer stalls past all-ones.
        v = idle; v.rst = 1'b1;
        run_cycle(v, 1'b0, "sat rst", hs);
        for (int ep = 0; ep < 11; ep++) begin
            v = idle; v.iv = 1'b1; v.iw = 1'b1; v.rd = 9; v.lat = LAT_DIV;
            run_cycle(v, 1'b0, "sat issue", hs);
            done = 1'b0;
            for (int c = 0; c < 12 && !done; c++) begin
                v = idle; v.s1 = 9; v.u1 = 1'b1;
                run_cycle(v, 1'b0, "sat wait", hs);
                done = !hs;
            end
            chk("sat release", 64'(done), 64'd1);
        end
        chk("stall saturated", 64'(stall_cycles), 64'(PMAX));
        v = idle; v.iv = 1'b1; v.iw = 1'b1; v.rd = 9; v.lat = LAT_DIV;
        run_cycle(v, 1'b0, "sat issue2", hs);
        for (int c = 0; c < 3; c++) begin
            v = idle; v.s1 = 9; v.u1 = 1'b1;
            run_cycle(v, 1'b0, "sat hold", hs);
        end
        chk("stall stays saturated", 64'(stall_cycles), 64'(PMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
